// File: rtl/lcd_ctrl_if.sv
// Signal bundle between the LSU LCD output register and the LCD write engine.
// The master drives the request word. The slave (the engine) returns the LCD bus and its status.
interface lcd_ctrl_if;
   logic [31:0] i_lcd_word;
   logic        o_lcd_on;
   logic        o_lcd_en;
   logic        o_lcd_rs;
   logic        o_lcd_rw;
   logic [7:0]  o_lcd_data;
   logic        o_busy;
   logic        o_ack_tgl;
   logic        o_overrun;

   modport master (
      output i_lcd_word,
      input  o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data,
      input  o_busy, o_ack_tgl, o_overrun
   );

   modport slave (
      input  i_lcd_word,
      output o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data,
      output o_busy, o_ack_tgl, o_overrun
   );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style character-LCD write engine driven by a toggle-request register.
// A request runs through setup, enable pulse, hold and execution wait, with one pending slot.
module lcd_ctrl #(
   parameter int SETUP_CYC   = 2,
   parameter int EN_HIGH_CYC = 12,
   parameter int HOLD_CYC    = 2,
   parameter int EXEC_CYC    = 2000,
   parameter int CLEAR_CYC   = 82000
) (
   input  logic      i_clk,
   input  logic      i_reset,
   lcd_ctrl_if.slave lcd
);

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYC, EN_HIGH_CYC),
                                          max_of(HOLD_CYC, EXEC_CYC)), CLEAR_CYC);
   localparam int CW = $clog2(MAX_CYC) + 1;

   localparam logic [CW-1:0] SETUP_LEN = CW'(SETUP_CYC);
   localparam logic [CW-1:0] EN_LEN    = CW'(EN_HIGH_CYC);
   localparam logic [CW-1:0] HOLD_LEN  = CW'(HOLD_CYC);
   localparam logic [CW-1:0] EXEC_LEN  = CW'(EXEC_CYC);
   localparam logic [CW-1:0] CLEAR_LEN = CW'(CLEAR_CYC);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tgl_q;
   logic          pend_valid_q, pend_valid_d;
   logic          pend_rs_q, pend_rs_d;
   logic [7:0]    pend_data_q, pend_data_d;
   logic          rs_q, rs_d;
   logic [7:0]    data_q, data_d;
   logic          ack_q, ack_d;
   logic          ovr_q, ovr_d;
   logic          en_q;
   logic          busy_q;
   logic          on_q;

   logic          req;
   logic          req_rs;
   logic [7:0]    req_data;
   logic          last_cycle;
   logic          wait_done;
   logic          cur_is_clear;
   logic          unused_word_bits;

   assign req          = lcd.i_lcd_word[30] ^ tgl_q;
   assign req_rs       = lcd.i_lcd_word[9];
   assign req_data     = lcd.i_lcd_word[7:0];
   assign last_cycle   = (cnt_q == CNT_ONE);
   assign wait_done    = (state_q == ST_WAIT) && last_cycle;
   assign cur_is_clear = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

   assign unused_word_bits = ^{lcd.i_lcd_word[29:10], lcd.i_lcd_word[8]};

   // Next-state logic. The pending slot and the end-of-wait handover are resolved after the
   // plain state progression, so that a request arriving on the last WAIT edge is never lost.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q - CNT_ONE;
      pend_valid_d = pend_valid_q;
      pend_rs_d    = pend_rs_q;
      pend_data_d  = pend_data_q;
      rs_d         = rs_q;
      data_d       = data_q;
      ack_d        = ack_q;
      ovr_d        = ovr_q;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (req) begin
               state_d = ST_SETUP;
               cnt_d   = SETUP_LEN;
               rs_d    = req_rs;
               data_d  = req_data;
            end
         end
         ST_SETUP: begin
            if (last_cycle) begin
               state_d = ST_PULSE;
               cnt_d   = EN_LEN;
            end
         end
         ST_PULSE: begin
            if (last_cycle) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LEN;
            end
         end
         ST_HOLD: begin
            if (last_cycle) begin
               state_d = ST_WAIT;
               cnt_d   = cur_is_clear ? CLEAR_LEN : EXEC_LEN;
            end
         end
         ST_WAIT: begin
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (wait_done) begin
         ack_d = ~ack_q;
         if (pend_valid_q) begin
            state_d      = ST_SETUP;
            cnt_d        = SETUP_LEN;
            rs_d         = pend_rs_q;
            data_d       = pend_data_q;
            pend_valid_d = req;
            if (req) begin
               pend_rs_d   = req_rs;
               pend_data_d = req_data;
            end
         end else if (req) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LEN;
            rs_d    = req_rs;
            data_d  = req_data;
         end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      end else if (req && (state_q != ST_IDLE)) begin
         if (pend_valid_q) begin
            ovr_d = 1'b1;
         end else begin
            pend_valid_d = 1'b1;
            pend_rs_d    = req_rs;
            pend_data_d  = req_data;
         end
      end
   end

   // EN and busy are registered from the next-state values so every output comes from a flop.
   // tgl_q follows bit 30 every cycle. When bit 30 matches tgl_q the load changes nothing;
   // when it differs, that edge accepts the request.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         tgl_q        <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_rs_q    <= 1'b0;
         pend_data_q  <= 8'h00;
         rs_q         <= 1'b0;
         data_q       <= 8'h00;
         ack_q        <= 1'b0;
         ovr_q        <= 1'b0;
         en_q         <= 1'b0;
         busy_q       <= 1'b0;
         on_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tgl_q        <= lcd.i_lcd_word[30];
         pend_valid_q <= pend_valid_d;
         pend_rs_q    <= pend_rs_d;
         pend_data_q  <= pend_data_d;
         rs_q         <= rs_d;
         data_q       <= data_d;
         ack_q        <= ack_d;
         ovr_q        <= ovr_d;
         en_q         <= (state_d == ST_PULSE);
         busy_q       <= (state_d != ST_IDLE) || pend_valid_d;
         on_q         <= lcd.i_lcd_word[31];
      end
   end

   assign lcd.o_lcd_on   = on_q;
   assign lcd.o_lcd_en   = en_q;
   assign lcd.o_lcd_rs   = rs_q;
   assign lcd.o_lcd_rw   = 1'b0;
   assign lcd.o_lcd_data = data_q;
   assign lcd.o_busy     = busy_q;
   assign lcd.o_ack_tgl  = ack_q;
   assign lcd.o_overrun  = ovr_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed self-checking bench for lcd_ctrl with shortened wait parameters.
// It covers single writes, clear/home timing, the pending slot, overrun, async reset and display power.
module tb_lcd_ctrl;

   localparam int S       = 2;
   localparam int E       = 12;
   localparam int H       = 2;
   localparam int W_EXEC  = 40;
   localparam int W_CLEAR = 150;
   localparam int T_EXEC  = S + E + H + W_EXEC;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   lcd_ctrl_if lcd();

   lcd_ctrl #(
      .SETUP_CYC   (S),
      .EN_HIGH_CYC (E),
      .HOLD_CYC    (H),
      .EXEC_CYC    (W_EXEC),
      .CLEAR_CYC   (W_CLEAR)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .lcd     (lcd)
   );

   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   logic tglState = 1'b0;
   logic onBit    = 1'b0;
   logic ackExp   = 1'b0;
   int   k;
   int   enHigh;
   int   enRises;
   int   busyLow;
   logic enPrev;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rs, input logic [7:0] data);
      tglState = ~tglState;
      lcd.i_lcd_word = {onBit, tglState, 20'b0, rs, 1'b0, data};
   endtask

   task automatic step();
      @(negedge clk);
      k++;
      if (lcd.o_lcd_en && !enPrev) enRises++;
      if (lcd.o_lcd_en) enHigh++;
      if (!lcd.o_busy) busyLow++;
      enPrev = lcd.o_lcd_en;
   endtask

   task automatic stepTo(input int target);
      while (k < target) step();
   endtask

   task automatic startWindow();
      k       = -1;
      enHigh  = 0;
      enRises = 0;
      busyLow = 0;
      enPrev  = lcd.o_lcd_en;
   endtask

   task automatic runSingle(input string tag, input logic rs, input logic [7:0] data, input int w);
      startWindow();
      applyStimulus(rs, data);
      stepTo(0);
      checkOutput({tag, "_busy_A"}, 32'(lcd.o_busy), 32'd1);
      checkOutput({tag, "_rs_A"}, 32'(lcd.o_lcd_rs), 32'(rs));
      checkOutput({tag, "_data_A"}, 32'(lcd.o_lcd_data), 32'(data));
      checkOutput({tag, "_en_A"}, 32'(lcd.o_lcd_en), 32'd0);
      stepTo(S - 1);
      checkOutput({tag, "_en_pre"}, 32'(lcd.o_lcd_en), 32'd0);
      stepTo(S);
      checkOutput({tag, "_en_rise"}, 32'(lcd.o_lcd_en), 32'd1);
      stepTo(S + E - 1);
      checkOutput({tag, "_en_last"}, 32'(lcd.o_lcd_en), 32'd1);
      stepTo(S + E);
      checkOutput({tag, "_en_fall"}, 32'(lcd.o_lcd_en), 32'd0);
      checkOutput({tag, "_data_hold"}, 32'(lcd.o_lcd_data), 32'(data));
      stepTo(S + E + H + w - 1);
      checkOutput({tag, "_busy_pre_ack"}, 32'(lcd.o_busy), 32'd1);
      checkOutput({tag, "_ack_pre"}, 32'(lcd.o_ack_tgl), 32'(ackExp));
      ackExp = ~ackExp;
      stepTo(S + E + H + w);
      checkOutput({tag, "_busy_done"}, 32'(lcd.o_busy), 32'd0);
      checkOutput({tag, "_ack_done"}, 32'(lcd.o_ack_tgl), 32'(ackExp));
      stepTo(S + E + H + w + 3);
      checkOutput({tag, "_en_pulses"}, 32'(enRises), 32'd1);
      checkOutput({tag, "_en_width"}, 32'(enHigh), 32'(E));
   endtask

   initial begin
      lcd.i_lcd_word = 32'h0;
      #2 rst_n = 1'b0;
      #5;
      checkOutput("rst_on", 32'(lcd.o_lcd_on), 32'd0);
      checkOutput("rst_en", 32'(lcd.o_lcd_en), 32'd0);
      checkOutput("rst_rs", 32'(lcd.o_lcd_rs), 32'd0);
      checkOutput("rst_rw", 32'(lcd.o_lcd_rw), 32'd0);
      checkOutput("rst_data", 32'(lcd.o_lcd_data), 32'd0);
      checkOutput("rst_busy", 32'(lcd.o_busy), 32'd0);
      checkOutput("rst_ack", 32'(lcd.o_ack_tgl), 32'd0);
      checkOutput("rst_ovr", 32'(lcd.o_overrun), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      runSingle("data41", 1'b1, 8'h41, W_EXEC);
      checkOutput("data41_word", lcd.i_lcd_word, 32'h4000_0241);
      runSingle("clear01", 1'b0, 8'h01, W_CLEAR);
      runSingle("func38", 1'b0, 8'h38, W_EXEC);
      runSingle("home02", 1'b0, 8'h02, W_CLEAR);
      runSingle("rs1_01", 1'b1, 8'h01, W_EXEC);
      repeat (3) @(negedge clk);

      // Two requests 10 cycles apart: the second leaves the pending slot with no idle gap.
      startWindow();
      applyStimulus(1'b1, 8'h41);
      stepTo(9);
      applyStimulus(1'b1, 8'h42);
      stepTo(T_EXEC - 1);
      checkOutput("b2b_data_first", 32'(lcd.o_lcd_data), 32'h41);
      checkOutput("b2b_ack_pre", 32'(lcd.o_ack_tgl), 32'(ackExp));
      ackExp = ~ackExp;
      stepTo(T_EXEC);
      checkOutput("b2b_ack_first", 32'(lcd.o_ack_tgl), 32'(ackExp));
      checkOutput("b2b_busy_mid", 32'(lcd.o_busy), 32'd1);
      checkOutput("b2b_data_second", 32'(lcd.o_lcd_data), 32'h42);
      checkOutput("b2b_en_setup", 32'(lcd.o_lcd_en), 32'd0);
      stepTo(T_EXEC + S - 1);
      checkOutput("b2b_en_pre", 32'(lcd.o_lcd_en), 32'd0);
      stepTo(T_EXEC + S);
      checkOutput("b2b_en_rise", 32'(lcd.o_lcd_en), 32'd1);
      stepTo(2 * T_EXEC - 1);
      checkOutput("b2b_no_idle_gap", 32'(busyLow), 32'd0);
      ackExp = ~ackExp;
      stepTo(2 * T_EXEC);
      checkOutput("b2b_ack_second", 32'(lcd.o_ack_tgl), 32'(ackExp));
      checkOutput("b2b_busy_done", 32'(lcd.o_busy), 32'd0);
      checkOutput("b2b_ovr", 32'(lcd.o_overrun), 32'd0);
      stepTo(2 * T_EXEC + 3);
      checkOutput("b2b_en_pulses", 32'(enRises), 32'd2);
      checkOutput("b2b_en_width", 32'(enHigh), 32'(2 * E));

      // Three requests inside one transaction: the third one is dropped and flagged.
      startWindow();
      applyStimulus(1'b1, 8'h41);
      stepTo(4);
      applyStimulus(1'b1, 8'h42);
      stepTo(8);
      applyStimulus(1'b1, 8'h43);
      stepTo(8);
      checkOutput("ovr_before", 32'(lcd.o_overrun), 32'd0);
      stepTo(9);
      checkOutput("ovr_set", 32'(lcd.o_overrun), 32'd1);
      ackExp = ~ackExp;
      stepTo(T_EXEC);
      checkOutput("ovr_ack_first", 32'(lcd.o_ack_tgl), 32'(ackExp));
      checkOutput("ovr_data_second", 32'(lcd.o_lcd_data), 32'h42);
      ackExp = ~ackExp;
      stepTo(2 * T_EXEC);
      checkOutput("ovr_ack_second", 32'(lcd.o_ack_tgl), 32'(ackExp));
      checkOutput("ovr_busy_done", 32'(lcd.o_busy), 32'd0);
      stepTo(2 * T_EXEC + 20);
      checkOutput("ovr_data_last", 32'(lcd.o_lcd_data), 32'h42);
      checkOutput("ovr_en_pulses", 32'(enRises), 32'd2);
      checkOutput("ovr_sticky", 32'(lcd.o_overrun), 32'd1);
      runSingle("after_ovr", 1'b1, 8'h55, W_EXEC);
      checkOutput("ovr_sticky_later", 32'(lcd.o_overrun), 32'd1);

      // Reset in the middle of the enable pulse, with a request pending.
      startWindow();
      applyStimulus(1'b1, 8'h61);
      stepTo(3);
      applyStimulus(1'b1, 8'h62);
      stepTo(6);
      checkOutput("rstp_en_before", 32'(lcd.o_lcd_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rstp_en_async", 32'(lcd.o_lcd_en), 32'd0);
      checkOutput("rstp_busy_async", 32'(lcd.o_busy), 32'd0);
      checkOutput("rstp_ovr_clear", 32'(lcd.o_overrun), 32'd0);
      checkOutput("rstp_ack_clear", 32'(lcd.o_ack_tgl), 32'd0);
      checkOutput("rstp_data_clear", 32'(lcd.o_lcd_data), 32'd0);
      ackExp = 1'b0;
      tglState = 1'b0;
      lcd.i_lcd_word = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      startWindow();
      stepTo(100);
      checkOutput("rstp_no_pulse", 32'(enRises), 32'd0);
      checkOutput("rstp_busy_idle", 32'(lcd.o_busy), 32'd0);

      // Display power bit follows with one cycle of latency and never starts a bus cycle.
      startWindow();
      onBit = 1'b1;
      lcd.i_lcd_word[31] = 1'b1;
      #1;
      checkOutput("on_before_edge", 32'(lcd.o_lcd_on), 32'd0);
      step();
      checkOutput("on_after_edge", 32'(lcd.o_lcd_on), 32'd1);
      onBit = 1'b0;
      lcd.i_lcd_word[31] = 1'b0;
      #1;
      checkOutput("off_before_edge", 32'(lcd.o_lcd_on), 32'd1);
      step();
      checkOutput("off_after_edge", 32'(lcd.o_lcd_on), 32'd0);
      stepTo(10);
      checkOutput("on_no_en", 32'(enRises), 32'd0);
      checkOutput("on_no_busy", 32'(lcd.o_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Hardware HD44780-style character-LCD write engine on the consumer side of the LSU's LCD output register (`o_io_lcd`). Software writes a command or data byte into that register and flips a request bit. This block detects the flip and generates the LCD bus cycle: setup, enable pulse, hold, then the controller's execution delay. It returns busy, acknowledge and overrun status, which can be wired back onto a readable input. A one-entry pending buffer lets software post a second request while one is in flight.

## Interface
- `SETUP_CYC`, default 2: cycles RS/DATA are stable before EN rises (≥1).
- `EN_HIGH_CYC`, default 12: EN high width in cycles (≥1).
- `HOLD_CYC`, default 2: cycles RS/DATA are held after EN falls (≥1).
- `EXEC_CYC`, default 2000: post-pulse wait for normal commands and data (≥1).
- `CLEAR_CYC`, default 82000: post-pulse wait for clear/home (RS=0, DATA=0x01 or 0x02) (≥1).
- `i_clk` input 1: sole clock, rising edge.
- `i_reset` input 1: asynchronous, active-low reset.
- `i_lcd_word` input 32: LSU LCD register. Fields:
  - [31] display power ON.
  - [30] request toggle.
  - [9] RS.
  - [7:0] DATA.
  - Other bits are ignored.
- `o_lcd_on` output 1: registered copy of `i_lcd_word[31]`.
- `o_lcd_en` output 1: LCD enable strobe.
- `o_lcd_rs` output 1: register select.
- `o_lcd_rw` output 1: constant 0 (write-only engine).
- `o_lcd_data` output 8: LCD data bus.
- `o_busy` output 1: request in flight or pending.
- `o_ack_tgl` output 1: toggles once per completed request.
- `o_overrun` output 1: sticky; a request was dropped.

## Operation
- `tgl_q` holds the last accepted toggle value. A request is detected at any rising edge where `i_lcd_word[30] != tgl_q`. That edge sets `tgl_q` to the new value and captures {RS, DATA}.
- The request is dispatched according to state and buffer occupancy:
  - IDLE: start immediately.
  - Any other state with the pending slot empty: store in the pending slot.
  - Pending slot full: discard the request and set `o_overrun`. `o_overrun` stays set until reset.
- FSM states:
  - IDLE: EN=0; the bus holds the last values.
  - SETUP: RS/DATA driven from the captured request; EN=0; lasts SETUP_CYC cycles.
  - PULSE: EN=1; lasts EN_HIGH_CYC cycles.
  - HOLD: EN=0, RS/DATA unchanged; lasts HOLD_CYC cycles.
  - WAIT: EN=0; lasts CLEAR_CYC cycles if the request is RS=0 with DATA 0x01/0x02, otherwise EXEC_CYC cycles.
- Transitions:
  - IDLE→SETUP on an accepted request.
  - SETUP→PULSE→HOLD→WAIT, each when its down-counter reaches its final cycle.
  - At WAIT end, `o_ack_tgl` inverts. Next state is SETUP with the pending request (slot cleared, no IDLE cycle) if the slot is full, otherwise IDLE.
- If a request arrives on the same edge WAIT ends and the slot is empty: it goes straight to SETUP as the next request, not to the slot. If the slot is full: the pending request is dispatched and the new one is stored.
- Counter: a single down-counter sized `$clog2(max parameter)+1` bits, reloaded on every state entry. A parameter value N gives exactly N cycles in that state.
- `o_busy` = (state != IDLE) | pending_valid.
- `o_lcd_on` updates every cycle, independent of the FSM.
- Reset, asynchronous, active-low:
  - State IDLE; counter, `tgl_q`, pending slot and `o_overrun` cleared.
  - All outputs 0: on, en, rs, rw, data=0x00, busy, ack_tgl.
  - Asserting reset mid-pulse drops EN immediately and discards any in-flight and pending requests.
  - If `i_lcd_word[30]` = 1 at reset release, the first clock edge accepts a request (because `tgl_q` resets to 0).

## Timing
- Accept edge = edge A. On edge A:
  - `o_busy` rises and the state enters SETUP.
  - `o_lcd_rs`/`o_lcd_data` take the new values.
- EN rises on edge A+SETUP_CYC.
- EN falls on edge A+SETUP_CYC+EN_HIGH_CYC.
- WAIT is entered on edge A+S+E+H, where S, E, H are SETUP_CYC, EN_HIGH_CYC, HOLD_CYC.
- `o_ack_tgl` flips, and `o_busy` falls if nothing is pending, on edge A+S+E+H+W, where W = EXEC_CYC or CLEAR_CYC.
- With default parameters: a data write occupies 2016 cycles from acceptance to ack; a clear occupies 82016.
- Back-to-back requests via the pending slot give an EN period of S+E+H+W cycles with no idle gap.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset with defaults → all outputs 0. Then write 0x4000_0241 (toggle=1, RS=1, DATA=0x41) → required response:
  - busy rises at edge A.
  - RS=1, DATA=0x41 from edge A.
  - EN high on edges A+2 through A+13 (12 cycles).
  - ack_tgl=1 and busy=0 at edge A+2016.
- RS=0, DATA=0x01 (clear) → WAIT lasts 82000 cycles; ack at A+82016. Repeat with DATA=0x38 → ack at A+2016.
- Two toggles 10 cycles apart (0x41 then 0x42) → second pulse SETUP starts at edge A+2016 with no IDLE cycle; two acks; `o_overrun`=0.
- Three toggles within one transaction → third request dropped; `o_overrun`=1 and stays 1 through later transactions until reset. Only two EN pulses are seen.
- Reset asserted during PULSE → EN=0 and busy=0 asynchronously, without waiting for a clock edge; pending request lost. After release with bit 30=0, no pulse occurs.
- Bit 31 toggled 0→1→0 with bit 30 constant → `o_lcd_on` follows with one-cycle latency; no EN activity.
